sevenseg_scan_driver: RTL and testbench

SEVENSEG_SCAN_DRIVER -- requirements
Module: sevenseg_scan_driver

---
 rtl/sevenseg_scan_driver_pkg.sv | 47 ++++
 rtl/sevenseg_scan_driver_bin2bcd_seq.sv | 112 +++++++++++
 rtl/sevenseg_scan_driver.sv | 114 +++++++++++
 tb/tb_sevenseg_scan_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: converter states,
// active-low segment codes (abcdefg, bit 6 = a) and digit helpers.
package sevenseg_scan_driver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction: a digit of 5 or more would exceed 9 once doubled.
  function automatic logic [3:0] dabble_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/sevenseg_scan_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 step per clock,
// committing all digits and the overflow flag together in a single cycle.
module bin2bcd_seq
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int NDIG = 8,
  parameter int W    = 27
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [W-1:0]      BIN,
  input  logic              LOAD,
  output logic [4*NDIG-1:0] BCD,
  output logic              OVF,
  output logic              BUSY,
  output logic              DONE
);

  localparam int BW    = 4 * NDIG;
  localparam int CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     bin_q, bin_d;
  logic [BW-1:0]    acc_q, acc_d;
  logic [BW-1:0]    acc_adj;
  logic             carry_q, carry_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < NDIG; i++) begin
      acc_adj[4*i +: 4] = dabble_adjust(acc_q[4*i +: 4]);
    end
  end

  always_comb begin
    // NOTE: every signal written here gets its hold value first, so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (LOAD) begin
          state_d = SHIFT;
          bin_d   = BIN;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // A bit leaving the top digit means the value needs more than NDIG digits.
        acc_d   = {acc_adj[BW-2:0], bin_q[W-1]};
        bin_d   = {bin_q[W-2:0], 1'b0};
        carry_d = carry_q | acc_adj[BW-1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        bcd_d   = acc_q;
        ovf_d   = carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      // NOTE: the committed digits are plain flops, not RAM, so they can and do take the async reset.
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop updates from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign BCD  = bcd_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Multiplexed seven-segment driver: converts a binary value to decimal digits
// and scans them one at a time onto registered active-low digit/segment lines.
module sevenseg_scan_driver
  import sevenseg_scan_driver_pkg::*;
#(
  parameter int NDIG     = 8,
  parameter int W        = 27,
  parameter int SCAN_DIV = 50000
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [W-1:0]    BIN,
  input  logic            LOAD,
  input  logic            LZB,
  input  logic [NDIG-1:0] DP_MASK,
  output logic            BUSY,
  output logic            DONE,
  output logic            OVF,
  output logic [NDIG-1:0] AN,
  output logic [6:0]      SEG_OUT,
  output logic            DP
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [NDIG-1:0]  AN_RESET = ~NDIG'(1);

  logic [4*NDIG-1:0] bcd;
  logic              ovf;

  bin2bcd_seq #(
    .NDIG (NDIG),
    .W    (W)
  ) u_conv (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BIN   (BIN),
    .LOAD  (LOAD),
    .BCD   (bcd),
    .OVF   (ovf),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       digit;
  logic             nz_at_or_above;
  logic             blank;

  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Display path works from the committed digits, so a commit shows up one clock later.
  always_comb begin
    an_d           = '1;
    dp_d           = 1'b1;
    digit          = '0;
    nz_at_or_above = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (IDX_W'(i) == idx_q) begin
        an_d[i] = 1'b0;
        digit   = bcd[4*i +: 4];
        dp_d    = ~DP_MASK[i];
      end
      if (IDX_W'(i) >= idx_q && bcd[4*i +: 4] != 4'd0) begin
        nz_at_or_above = 1'b1;
      end
    end

    blank = LZB && !ovf && (idx_q != '0) && !nz_at_or_above;

    if (ovf) begin
      seg_d = SEG_DASH;
    end else if (blank) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = digit_to_seg(digit);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= AN_RESET;
      seg_q <= SEG_0;
      dp_q  <= 1'b1;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign OVF     = ovf;
  assign AN      = an_q;
  assign SEG_OUT = seg_q;
  assign DP      = dp_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Self-checking bench for sevenseg_scan_driver: a cycle-level reference model
// derived from decimal arithmetic plus directed scenarios with literal expectations.
module tb_sevenseg_scan_driver;

  localparam int NDIG     = 8;
  localparam int W        = 27;
  localparam int SCAN_DIV = 4;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [W-1:0]    BIN;
  logic            LOAD;
  logic            LZB;
  logic [NDIG-1:0] DP_MASK;
  logic            BUSY;
  logic            DONE;
  logic            OVF;
  logic [NDIG-1:0] AN;
  logic [6:0]      SEG_OUT;
  logic            DP;

  int n_checks = 0;
  int n_pass   = 0;

  sevenseg_scan_driver #(
    .NDIG     (NDIG),
    .W        (W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .BIN     (BIN),
    .LOAD    (LOAD),
    .LZB     (LZB),
    .DP_MASK (DP_MASK),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVF     (OVF),
    .AN      (AN),
    .SEG_OUT (SEG_OUT),
    .DP      (DP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int j = 0; j < n; j++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] digit_code(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Decimal digit i of the committed value, with overflow dashes and leading-zero blanking.
  function automatic logic [6:0] model_seg(input longint unsigned v, input bit ovf,
                                           input int i, input logic lzb);
    longint unsigned p = pow10(i);
    if (ovf) return 7'b1111110;
    if (lzb === 1'b1 && i != 0 && v < p) return 7'b1111111;
    return digit_code(int'((v / p) % 10));
  endfunction

  // Reference model: t counts edges since reset release; a conversion accepted at
  // edge t_acc commits at edge t_acc+W+1, and the display lags the commit by one edge.
  longint unsigned com_v, v_acc;
  bit              com_ovf, pend;
  int              t, t_acc, idx;
  logic            e_busy, e_done, e_dp;
  logic [NDIG-1:0] e_an;
  logic [6:0]      e_seg;

  always @(posedge CLK) begin
    if (!RST_N) begin
      t = 0; pend = 0; com_v = 0; com_ovf = 0;
      e_busy = 0; e_done = 0; e_an = ~NDIG'(1); e_seg = 7'b0000001; e_dp = 1;
    end else begin
      t++;
      idx   = ((t - 1) / SCAN_DIV) % NDIG;
      e_an  = ~(NDIG'(1) << idx);
      e_dp  = ~DP_MASK[idx];
      e_seg = model_seg(com_v, com_ovf, idx, LZB);
      e_done = 0;
      if (pend && t == t_acc + W + 1) begin
        com_v   = v_acc;
        com_ovf = (v_acc >= pow10(NDIG));
        pend    = 0;
        e_done  = 1;
      end else if (!pend && LOAD === 1'b1) begin
        pend  = 1;
        t_acc = t;
        v_acc = 64'(BIN);
      end
      e_busy = pend;
    end
    #1;
    check("model_BUSY", BUSY, e_busy);
    check("model_DONE", DONE, e_done);
    check("model_OVF", OVF, com_ovf);
    check("model_AN", AN, e_an);
    check("model_SEG", SEG_OUT, e_seg);
    check("model_DP", DP, e_dp);
  end

  logic [6:0] cap_seg [NDIG];
  logic       cap_dp  [NDIG];
  int         cap_cnt [NDIG];
  int         wraps;

  // Samples one full scan plus one slot, recording what each digit slot shows.
  task automatic capture();
    int cur, prev;
    prev = -1;
    wraps = 0;
    for (int i = 0; i < NDIG; i++) cap_cnt[i] = 0;
    for (int s = 0; s <= NDIG * SCAN_DIV; s++) begin
      @(negedge CLK);
      cur = -1;
      for (int i = 0; i < NDIG; i++) if (AN[i] === 1'b0) cur = i;
      if (cur >= 0) begin
        cap_seg[cur] = SEG_OUT;
        cap_dp[cur]  = DP;
        if (s < NDIG * SCAN_DIV) cap_cnt[cur]++;
      end
      if (prev == NDIG - 1 && cur == 0) wraps++;
      prev = cur;
    end
  endtask

  task automatic do_load(input logic [W-1:0] v, output int lat);
    @(negedge CLK);
    BIN  = v;
    LOAD = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    LOAD = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK);
      #1;
      if (DONE === 1'b1) begin
        lat = c;
        break;
      end
    end
    @(posedge CLK);
  endtask

  initial begin
    int lat;
    int dones;
    int done_at[$];

    RST_N = 1'b0; LOAD = 1'b0; BIN = '0; LZB = 1'b0; DP_MASK = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_AN", AN, 8'hFE);
    check("rst_SEG", SEG_OUT, 7'b0000001);
    check("rst_DP", DP, 1'b1);
    check("rst_BUSY", BUSY, 1'b0);
    check("rst_DONE", DONE, 1'b0);
    check("rst_OVF", OVF, 1'b0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    LZB = 1'b1;
    do_load(27'd5999, lat);
    check("latency_5999", lat, 28);
    capture();
    check("d3_5999", cap_seg[3], 7'b0100100);
    for (int i = 0; i < 3; i++) check("d0to2_5999", cap_seg[i], 7'b0000100);
    for (int i = 4; i < NDIG; i++) check("blank_5999", cap_seg[i], 7'b1111111);

    do_load(27'd0, lat);
    check("latency_0", lat, 28);
    capture();
    check("d0_zero_lzb", cap_seg[0], 7'b0000001);
    for (int i = 1; i < NDIG; i++) check("blank_zero_lzb", cap_seg[i], 7'b1111111);
    LZB = 1'b0;
    capture();
    for (int i = 0; i < NDIG; i++) check("zero_nolzb", cap_seg[i], 7'b0000001);

    do_load(27'd100000000, lat);
    check("ovf_set", OVF, 1'b1);
    capture();
    for (int i = 0; i < NDIG; i++) check("dash_ovf", cap_seg[i], 7'b1111110);
    do_load(27'd99999999, lat);
    check("ovf_clear", OVF, 1'b0);
    capture();
    for (int i = 0; i < NDIG; i++) check("nines", cap_seg[i], 7'b0000100);

    DP_MASK = 8'b00000100;
    capture();
    for (int i = 0; i < NDIG; i++) check("dp_slot", cap_dp[i], (i == 2) ? 1'b0 : 1'b1);
    for (int i = 0; i < NDIG; i++) check("slot_len", cap_cnt[i], SCAN_DIV);
    check("scan_wrap", wraps, 1);

    // LOAD held high: the commit edge ignores LOAD, so accepts are W+2 edges apart.
    @(negedge CLK);
    LZB = 1'b1;
    LOAD = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      BIN = W'(c * 1234567 + 89);
      if (DONE === 1'b1) done_at.push_back(c);
    end
    LOAD = 1'b0;
    check("held_done_count", done_at.size(), 3);
    for (int i = 1; i < done_at.size(); i++)
      check("held_done_spacing", done_at[i] - done_at[i-1], W + 2);
    repeat (40) @(negedge CLK);

    @(negedge CLK);
    BIN  = 27'd4321;
    LOAD = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    LOAD = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_BUSY", BUSY, 1'b0);
    check("midrst_DONE", DONE, 1'b0);
    check("midrst_AN", AN, 8'hFE);
    check("midrst_SEG", SEG_OUT, 7'b0000001);
    check("midrst_DP", DP, 1'b1);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE === 1'b1) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_idle", BUSY, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
